mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   Iterative signed multiply/divide responder for the multicycle CPU. The control FSM
//   raises a one-cycle start with operands from A/B. This block runs WIDTH iteration
//   cycles, then pulses done. The control FSM then loads hi_out/lo_out into the HI/LO
//   registers. MIPS semantics: mult writes the {HI,LO} product; div writes quotient to LO
//   and remainder to HI.
// PARAMETERS
//   WIDTH  32  operand width; also the iteration count; product is 2*WIDTH bits
// PORTS
//   clock       in   1      system clock, rising edge
//   reset       in   1      asynchronous, active-high; clears all state and outputs
//   start_mult  in   1      1-cycle request: signed a_in * b_in
//   start_div   in   1      1-cycle request: signed a_in / b_in
//   a_in        in   WIDTH  multiplicand / dividend, sampled only on the accepting edge
//   b_in        in   WIDTH  multiplier / divisor, sampled only on the accepting edge
//   busy        out  1      high while iterating (MULT or DIV state)
//   done        out  1      one-cycle pulse; hi_out/lo_out valid while high and held after
//   div_zero    out  1      high with done when a div had b_in==0
//   hi_out      out  WIDTH  product[2W-1:W] or remainder
//   lo_out      out  WIDTH  product[W-1:0] or quotient
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, div_zero=0, hi_out=0, lo_out=0; counter=0.
//   States:
//   - IDLE: start_mult -> MULT; else start_div with b_in!=0 -> DIV;
//     start_div with b_in==0 -> DONE with div_zero=1.
//     start_mult wins if both starts are high. Operands latch on the accepting edge k.
//   - MULT: radix-2 Booth, one step per cycle, counter 0..WIDTH-1. The last step is at
//     edge k+WIDTH, which also loads hi_out/lo_out and moves to DONE.
//   - DIV: restoring divide on operand magnitudes, one quotient bit per cycle. The last
//     step is at edge k+WIDTH; signs are fixed up there and registered into hi/lo; -> DONE.
//   - DONE: done=1 (and div_zero if applicable) for exactly one cycle, then -> IDLE.
//   Latency:
//   - mult/div: done visible in the cycle after edge k+WIDTH; busy high in cycles
//     k+1..k+WIDTH.
//   - Divide by zero: done in the cycle after edge k; busy never rises; hi_out/lo_out
//     are left unchanged.
//   Starts: accepted only in IDLE. A start in MULT/DIV/DONE is ignored, not queued.
//   Arithmetic:
//   - All operands are two's complement.
//   - Quotient truncates toward zero; remainder takes the sign of the dividend.
//   - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; no flag.
//   - Product is the exact 64-bit signed result; no overflow is possible.
//   Hold: hi_out/lo_out change only when an operation completes (or on reset).
//     done and div_zero are 0 outside DONE.
//   Reset mid-operation: abort immediately to the reset values. No done is produced for
//     the aborted operation.
// TESTING
//   1. mult 7 * -3 -> done at cycle k+WIDTH+1; hi=0xFFFFFFFF, lo=0xFFFFFFEB;
//      busy high for exactly 32 cycles.
//   2. mult 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000;
//      0xFFFFFFFF * 0xFFFFFFFF -> hi=0, lo=1.
//   3. div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 100 / 7 -> lo=14, hi=2;
//      div 0x80000000 / -1 -> lo=0x80000000, hi=0.
//   4. div 5 / 0 with prior hi=2, lo=14 -> done and div_zero high one cycle after start;
//      hi/lo still 2/14; busy stays 0.
//   5. start_div pulsed at cycle k+10 of a running mult, and both starts high in IDLE ->
//      the second start is ignored; the mult result comes out unchanged; the dual start
//      runs mult.
//   6. Assert reset at iteration 15 of a div -> all outputs 0 asynchronously; no done
//      afterwards; a new mult issued after reset completes correctly.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit for the multicycle CPU.
// One iteration per cycle for WIDTH cycles, then a one-cycle done pulse with HI/LO results.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  // Booth accumulator: {A (WIDTH+1), Q (WIDTH), q_-1}; A is one bit wider so -2^(W-1)
  // as multiplicand cannot overflow the add/subtract.
  logic [2*WIDTH+1:0]  acc_q, acc_d;
  logic [WIDTH:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0]    dvs_q, dvs_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic                dz_q, dz_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;

  logic [WIDTH:0]      booth_a, booth_sum;
  logic [2*WIDTH+1:0]  acc_step;
  logic [WIDTH:0]      div_shift, div_trial;
  logic [WIDTH-1:0]    rem_step, quo_step;
  logic [WIDTH-1:0]    a_mag, b_mag;

  // Single-iteration datapath for both operations
  always_comb begin
    booth_a = acc_q[2*WIDTH+1:WIDTH+1];
    case (acc_q[1:0])
      2'b01:   booth_sum = booth_a + mcand_q;
      2'b10:   booth_sum = booth_a - mcand_q;
      default: booth_sum = booth_a;
    endcase
    acc_step = {booth_sum[WIDTH], booth_sum, acc_q[WIDTH:1]};

    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, dvs_q};
    if (!div_trial[WIDTH]) begin
      rem_step = div_trial[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = div_shift[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end

    a_mag = a_in[WIDTH-1] ? -a_in : a_in;
    b_mag = b_in[WIDTH-1] ? -b_in : b_in;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      StIdle: begin
        if (start_mult) begin
          state_d = StMult;
          cnt_d   = '0;
          acc_d   = {{(WIDTH+1){1'b0}}, b_in, 1'b0};
          mcand_d = {a_in[WIDTH-1], a_in};
          dz_d    = 1'b0;
        end else if (start_div) begin
          if (b_in == '0) begin
            // Divide by zero: flag it and leave HI/LO untouched
            state_d = StDone;
            dz_d    = 1'b1;
          end else begin
            state_d = StDiv;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            q_neg_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            r_neg_d = a_in[WIDTH-1];
            dz_d    = 1'b0;
          end
        end
      end
      StMult: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          hi_d    = acc_step[2*WIDTH:WIDTH+1];
          lo_d    = acc_step[WIDTH:1];
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDiv: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          lo_d    = q_neg_q ? -quo_step : quo_step;
          hi_d    = r_neg_q ? -rem_step : rem_step;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == StMult) || (state_q == StDiv);
  assign done     = (state_q == StDone);
  assign div_zero = (state_q == StDone) && dz_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule
